muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EXE stage of the core pipeline. It consumes the already-forwarded EXE operands, the same values the EXE forwarding muxes select for the ALU. It holds the pipeline via `stall` while an operation is in flight, then returns one result with its destination register for the EXE/MEM register. Multiply takes a fixed 2 cycles, divide/remainder a fixed 33 cycles, and divide-by-zero/overflow special cases take 1 cycle.

## Interface
Parameters:
- `XLEN`, 32, operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  EXE holds a valid M-extension instruction.
- `funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operand_a`  in  XLEN  forwarded rs1 value.
- `operand_b`  in  XLEN  forwarded rs2 value.
- `rd_in`  in  5  destination register.
- `flush`  in  1  kill the in-flight operation (branch/trap).
- `stall`  out  1  hold IF/ID/EXE.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  XLEN  result, held until the next accepted start.
- `rd_out`  out  5  rd latched at accept.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - With `start & ~flush`: latch funct3, operands and rd, then branch:
    - MUL-class → MUL.
    - Divide with divisor 0, or DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF → DONE with the special result registered.
    - Otherwise → DIV with `count` = 0.
- MUL:
  - Compute the 64-bit product of 33-bit extended operands.
    - MULH: both operands signed.
    - MULHSU: a signed, b unsigned.
    - MULHU and MUL: both unsigned.
  - Register the selected half: MUL takes [31:0], all others take [63:32].
  - → DONE.
- DIV:
  - Radix-2 restoring divide on |a| and |b| (absolute values only for signed DIV/REM), one quotient bit per cycle.
  - 6-bit `count`. Go → DONE after the iteration with `count` = 31, registering the final result that cycle.
  - Sign fix-up:
    - Quotient is negated if the signs of a and b differ.
    - Remainder takes the sign of a.
    - A zero remainder stays zero.
- DONE: `done` = 1, `result`/`rd_out` valid. → IDLE. A `start` in this cycle is ignored; the pipeline advances this cycle, so the next instruction arrives in the following cycle.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU), remainder = a.
  - Signed overflow: quotient 0x80000000, remainder 0.
- `start` while busy is ignored; latched operands are not disturbed.
- `flush`:
  - In any state, next state is IDLE, `done` is not asserted and `result` keeps its old value.
  - `flush` together with `start` in IDLE: the start is discarded.
- `reset`: state IDLE, `count` 0, `done` 0, `busy` 0, `result` 0, `rd_out` 0, internal registers 0.

## Timing
- T = accepting cycle (IDLE, `start`=1).
- `stall` = (`start` & ~`flush` & state==IDLE) | state∈{MUL, DIV}. It is combinational and low in DONE.
- `busy` is registered: high from T+1 through the DONE cycle inclusive.
- `done` is registered and high for exactly one cycle:
  - MUL-class: `done` at T+2.
  - Normal divide: `done` at T+33.
  - Special-case divide: `done` at T+1.
- `result`/`rd_out` change only on the edge entering DONE, and stay stable until the next DONE.
- Back-to-back instructions: earliest next accept is the cycle after DONE. MUL→MUL throughput is 1 per 3 cycles.
- Reset mid-operation: all outputs read their reset values on the next cycle.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → `stall` high at T and T+1, `done` at T+2, `result`=0xFFFFFFEB, `rd_out`=5. MULH with a = b = 0x80000000 → 0x40000000. MULHSU with a = b = 0xFFFFFFFF → 0xFFFFFFFF. MULHU with a = b = 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → `done` at T+33 with 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. `stall` high for T..T+32, low at T+33.
- DIVU 0x1234/0 → `done` at T+1 with 0xFFFFFFFF. REM 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Flush at T+10 of a DIV → `busy` 0 at T+11, no `done` pulse, `result` unchanged. A new MUL started at T+11 completes at T+13.
- A second `start` with different operands at T+5 of a DIV → ignored, original result at T+33. `start` in the DONE cycle → not accepted.
- `reset` asserted at T+3 of a DIV → next cycle `busy`=0, `done`=0, `result`=0, `rd_out`=0, `stall`=0 with `start` low.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EXE stage.
// Multiply finishes in 2 cycles, restoring divide in 33 cycles and the
// divide-by-zero / signed-overflow cases in 1 cycle. The pipeline is held
// via stall while an operation is in flight; result and rd_out are
// registered on the edge entering DONE and held until the next DONE.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic [5:0]      count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    // ---------------- accept-time decode ----------------
    logic            accept;
    logic            sdiv;       // signed DIV/REM
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN-1:0] spec_res;

    assign accept   = start & ~flush & (state_q == S_IDLE);
    assign sdiv     = funct3[2] & ~funct3[0];
    assign div_zero = (operand_b == '0);
    assign div_ovf  = sdiv & (operand_a == INT_MIN) & (operand_b == ALL_ONE);
    assign abs_a    = (sdiv & operand_a[XLEN-1]) ? -operand_a : operand_a;
    assign abs_b    = (sdiv & operand_b[XLEN-1]) ? -operand_b : operand_b;
    // funct3[1] selects remainder: by-zero gives a / all-ones, overflow gives 0 / INT_MIN
    assign spec_res = div_zero ? (funct3[1] ? operand_a : ALL_ONE)
                               : (funct3[1] ? '0 : INT_MIN);

    // ---------------- multiply datapath ----------------
    // Operands are extended to 64 bits with the per-op sign; the low 64 bits
    // of the product are the same as the 33x33 signed product.
    logic            a_sgn, b_sgn;
    logic [63:0]     a64, b64, prod;
    logic [XLEN-1:0] mul_res;

    assign a_sgn   = ((f3_q == 3'd1) | (f3_q == 3'd2)) & a_q[XLEN-1];
    assign b_sgn   = (f3_q == 3'd1) & b_q[XLEN-1];
    assign a64     = {{32{a_sgn}}, a_q};
    assign b64     = {{32{b_sgn}}, b_q};
    assign prod    = a64 * b64;
    assign mul_res = (f3_q == 3'd0) ? prod[31:0] : prod[63:32];

    // ---------------- restoring divide step ----------------
    // Shift the next dividend bit into the partial remainder, subtract the
    // divisor and keep the difference when it did not borrow.
    logic [XLEN:0]   rem_sh, diff;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin, div_res;

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign ge      = ~diff[XLEN];
    assign rem_n   = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], ge};
    assign q_fin   = qneg_q ? -quo_n : quo_n;
    assign r_fin   = rneg_q ? -rem_n : rem_n;   // -0 is still 0
    assign div_res = f3_q[1] ? r_fin : q_fin;

    // ---------------- outputs ----------------
    assign stall  = accept | (state_q == S_MUL) | (state_q == S_DIV);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

    // Next-state and datapath register update
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d = funct3;
                    a_d  = operand_a;
                    b_d  = operand_b;
                    rd_d = rd_in;
                    if (!funct3[2]) begin
                        state_d = S_MUL;
                    end else if (div_zero | div_ovf) begin
                        result_d = spec_res;
                        rd_out_d = rd_in;
                        state_d  = S_DONE;
                    end else begin
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        qneg_d  = sdiv & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                        rneg_d  = sdiv & operand_a[XLEN-1];
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = mul_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_n;
                    quo_d   = quo_n;
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        result_d = div_res;
                        rd_out_d = rd_q;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random scoreboard bench for muldiv_unit.
// Inputs are driven and outputs sampled on the falling edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];      // {rd, result}
    logic [31:0] prev_exp = '0; // last completed result

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .flush(flush), .stall(stall), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built on the simulator's own integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] u;
        int sa, sb;
        logic ovf;
        sa  = int'(a);
        sb  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); u = p; return u[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); u = p; return u[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op at the current falling edge and follow it to DONE.
    // poke_k: cycle offset at which a spurious start is applied (0 = none).
    // start_in_done: drive a start during the DONE cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input int poke_k, input bit start_in_done);
        logic [36:0] e;
        int k;
        funct3 = f3; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
        #1;
        chk("stall_accept", 32'(stall), 32'd1);
        exp_q.push_back({rd, exp});
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            chk("stall_busy", 32'(stall), 32'd1);
            chk("busy_inflight", 32'(busy), 32'd1);
            if (k == poke_k) begin
                funct3 = 3'd0; operand_a = 32'h5; operand_b = 32'h9; rd_in = 5'd31; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        chk("latency", 32'(k), 32'(lat));
        e = exp_q.pop_front();
        chk("result", result, e[31:0]);
        chk("rd_out", 32'(rd_out), 32'(e[36:32]));
        chk("busy_done", 32'(busy), 32'd1);
        if (start_in_done) begin
            funct3 = 3'd3; operand_a = 32'hFFFF_FFFF; operand_b = 32'h2; rd_in = 5'd9; start = 1'b1;
            #1;
        end
        chk("stall_done", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("result_hold", result, e[31:0]);
        prev_exp = e[31:0];
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Multiply family, back to back
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2, 0, 0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 2, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 2, 0, 0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 2, 0, 1);

        // Normal divides; the first one sees a stray start at T+5
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2, 5'd10, 32'hFFFF_FFFD, 33, 5, 0);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2, 5'd11, 32'hFFFF_FFFF, 33, 0, 0);
        run_op(3'd5, 32'd100,        32'd7, 5'd12, 32'd14,        33, 0, 0);
        run_op(3'd7, 32'd100,        32'd7, 5'd13, 32'd2,         33, 0, 1);

        // Special cases
        run_op(3'd5, 32'h1234,       32'd0,          5'd14, 32'hFFFF_FFFF, 1, 0, 0);
        run_op(3'd6, 32'h1234,       32'd0,          5'd15, 32'h1234,      1, 0, 0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000, 1, 0, 0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h0,         1, 0, 0);

        // Flush at T+10 of a DIV, then a MUL accepted at T+11
        funct3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            chk("flush_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, prev_exp);
        run_op(3'd0, 32'd12, 32'd11, 5'd21, 32'd132, 2, 0, 0);

        // Flush together with start in IDLE discards the start
        funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd3; rd_in = 5'd2; start = 1'b1; flush = 1'b1;
        #1;
        chk("flushstart_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", 32'(busy), 32'd0);

        // Random operands against the model
        for (int i = 0; i < 12; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(rf3, ra, rb, 5'(i + 1), model(rf3, ra, rb), lat_of(rf3, ra, rb), 0, 0);
        end

        // Reset at T+3 of a DIV
        funct3 = 3'd5; operand_a = 32'hDEAD_BEEF; operand_b = 32'd13; rd_in = 5'd25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd", 32'(rd_out), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd13, 5'd26, 32'hDEAD_BEEF % 32'd13, 33, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
